// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one operand pair per start, two multiplier bits per cycle.
// Optional build macro BOOTH_UNSIGNED_EN selects unsigned operands (one extra Booth digit).
module booth_seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   product,
    output logic [4:0]           sel
);

    localparam int PW = 2 * WIDTH;
`ifdef BOOTH_UNSIGNED_EN
    localparam int DIGITS = WIDTH / 2 + 1;
`else
    localparam int DIGITS = WIDTH / 2;
`endif
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Multiplier plus the implicit B[-1]=0 below and two extension bits above.
    localparam int BW = WIDTH + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic signed [PW-1:0]  a_reg;
    logic [BW-1:0]         b_reg;
    logic signed [PW-1:0]  acc;
    logic signed [PW-1:0]  acc_next;
    logic [CW-1:0]         digit;
    logic [4:0]            sel_cur;
    logic signed [PW-1:0]  a_ext;
    logic [BW-1:0]         b_ext;

    function automatic logic [4:0] decode_digit(input logic [2:0] trip);
        logic [4:0] onehot;
        case (trip)
            3'b001, 3'b010: onehot = 5'b00010;
            3'b011:         onehot = 5'b01000;
            3'b100:         onehot = 5'b10000;
            3'b101, 3'b110: onehot = 5'b00100;
            default:        onehot = 5'b00001;
        endcase
        return onehot;
    endfunction

    function automatic logic signed [PW-1:0] select_multiple(input logic [4:0] onehot,
                                                             input logic signed [PW-1:0] a);
        logic signed [PW-1:0] m;
        if (onehot[1])      m = a;
        else if (onehot[2]) m = -a;
        else if (onehot[3]) m = a <<< 1;
        else if (onehot[4]) m = -(a <<< 1);
        else                m = '0;
        return m;
    endfunction

`ifdef BOOTH_UNSIGNED_EN
    assign a_ext = {{WIDTH{1'b0}}, multiplicand};
    assign b_ext = {2'b00, multiplier, 1'b0};
`else
    assign a_ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
    assign b_ext = {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0};
`endif

    // a_reg and b_reg shift by one digit per RUN cycle, so the current triplet is always b_reg[2:0].
    assign sel_cur  = decode_digit(b_reg[2:0]);
    assign acc_next = acc + select_multiple(sel_cur, a_reg);

    assign ready     = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);
    assign sel       = (state == S_RUN) ? sel_cur : 5'b00000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            digit   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= a_ext;
                        b_reg <= b_ext;
                        acc   <= '0;
                        digit <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    a_reg <= a_reg <<< 2;
                    b_reg <= b_reg >> 2;
                    // Product is captured with the last digit so it is final while out_valid is high.
                    if (digit == CW'(DIGITS - 1)) begin
                        product <= acc_next;
                        state   <= S_DONE;
                    end else begin
                        digit <= digit + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Randomized self-checking bench for booth_seq_mult_ctrl against an arithmetic Booth reference.
module tb_booth_seq_mult_ctrl;

    localparam int W  = 8;
    localparam int PW = 2 * W;
`ifdef BOOTH_UNSIGNED_EN
    localparam bit UNS = 1'b1;
    localparam int N   = W / 2 + 1;
`else
    localparam bit UNS = 1'b0;
    localparam int N   = W / 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic          ready;
    logic          busy;
    logic          out_valid;
    logic [PW-1:0] product;
    logic [4:0]    sel;

    int vectors = 0;
    int miscompares = 0;
    logic [PW-1:0] last_prod = '0;

    always #5 clk = ~clk;

    booth_seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .ready(ready), .busy(busy), .out_valid(out_valid),
        .product(product), .sel(sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int op_value(input logic [W-1:0] v);
        int x = int'(v);
        if (!UNS && v[W-1]) x = x - (1 << W);
        return x;
    endfunction

    function automatic logic [PW-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        return PW'(op_value(a) * op_value(b));
    endfunction

    function automatic int bbit(input logic [W-1:0] b, input int j);
        if (j < 0) return 0;
        if (j >= W) return UNS ? 0 : int'(b[W-1]);
        return int'(b[j]);
    endfunction

    // Booth digit value d = -2*b[2k+1] + b[2k] + b[2k-1], mapped to the one-hot select.
    function automatic logic [4:0] ref_sel(input logic [W-1:0] b, input int k);
        int d = -2 * bbit(b, 2*k + 1) + bbit(b, 2*k) + bbit(b, 2*k - 1);
        case (d)
            0:       return 5'b00001;
            1:       return 5'b00010;
            -1:      return 5'b00100;
            2:       return 5'b01000;
            -2:      return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_start", ready, 1);
    endtask

    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        logic [PW-1:0] exp_p;
        exp_p = ref_product(a, b);
        wait_ready();
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        for (int k = 0; k < N; k++) begin
            chk("busy_run", busy, 1);
            chk("ready_run", ready, 0);
            chk("out_valid_run", out_valid, 0);
            chk("sel_digit", sel, ref_sel(b, k));
            chk("product_hold", product, last_prod);
            @(posedge clk);
            @(negedge clk);
        end
        chk("out_valid_done", out_valid, 1);
        chk("product_done", product, exp_p);
        chk("busy_done", busy, 0);
        chk("ready_done", ready, 0);
        chk("sel_done", sel, 0);
        last_prod = exp_p;
        @(negedge clk);
        chk("out_valid_pulse", out_valid, 0);
        chk("ready_after", ready, 1);
        chk("product_keep", product, last_prod);
    endtask

    initial begin
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_sel", sel, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_mult(8'd7, 8'hFD, 1'b0);
        do_mult(8'h80, 8'h80, 1'b0);
        do_mult(8'h7F, 8'h80, 1'b0);
        do_mult(8'hFF, 8'hFF, 1'b1);
        do_mult(8'h80, 8'h7F, 1'b0);
        for (int t = 0; t < 40; t++)
            do_mult(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
        do_mult(8'h55, 8'hAA, 1'b0);

        // Abort an operation during its third RUN cycle.
        wait_ready();
        multiplicand = 8'd9;
        multiplier   = 8'd11;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_product", product, 0);
        chk("abort_sel", sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_prod = '0;
        for (int c = 0; c < N + 3; c++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
            chk("abort_idle", ready, 1);
        end
        do_mult(8'd5, 8'd6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
